// File: rtl/button_event_gen.sv
// Turns a debounced switch level into press, release, long-press and auto-repeat pulses.
// Also tracks a held level and a wrapping press counter. All outputs are registered.
module button_event_gen #(
  parameter int c_Long_Press_Limit = 25000000,
  parameter int c_Repeat_Limit     = 5000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Long_Press,
  output logic       o_Repeat,
  output logic       o_Held,
  output logic [7:0] o_Press_Count
);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  localparam logic [24:0] LONG_LAST   = 25'(c_Long_Press_Limit - 1);
  localparam logic [24:0] REPEAT_LAST = 25'(c_Repeat_Limit - 1);

  state_t      state;
  logic [24:0] count;
  logic        r_Prev;
  logic        press_edge;
  logic        release_edge;

  assign press_edge   = i_Switch & ~r_Prev;
  assign release_edge = ~i_Switch & r_Prev;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      count         <= '0;
      r_Prev        <= 1'b0;
      o_Press       <= 1'b0;
      o_Release     <= 1'b0;
      o_Long_Press  <= 1'b0;
      o_Repeat      <= 1'b0;
      o_Held        <= 1'b0;
      o_Press_Count <= 8'd0;
    end else begin
      r_Prev       <= i_Switch;
      o_Press      <= 1'b0;
      o_Release    <= 1'b0;
      o_Long_Press <= 1'b0;
      o_Repeat     <= 1'b0;
      case (state)
        IDLE: begin
          if (press_edge) begin
            state         <= PRESSED;
            count         <= '0;
            o_Press       <= 1'b1;
            o_Held        <= 1'b1;
            o_Press_Count <= o_Press_Count + 8'd1;
          end
        end
        PRESSED: begin
          // Release is checked first so a release on the limit cycle suppresses the long-press.
          if (release_edge) begin
            state     <= IDLE;
            count     <= '0;
            o_Release <= 1'b1;
            o_Held    <= 1'b0;
          end else if (i_Switch) begin
            if (count == LONG_LAST) begin
              state        <= REPEAT;
              count        <= '0;
              o_Long_Press <= 1'b1;
            end else begin
              count <= count + 25'd1;
            end
          end
        end
        REPEAT: begin
          if (release_edge) begin
            state     <= IDLE;
            count     <= '0;
            o_Release <= 1'b1;
            o_Held    <= 1'b0;
          end else if (i_Switch) begin
            if (count == REPEAT_LAST) begin
              count    <= '0;
              o_Repeat <= 1'b1;
            end else begin
              count <= count + 25'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          count  <= '0;
          o_Held <= 1'b0;
        end
      endcase
    end
  end

endmodule
